// File: rtl/xform_sched_if.sv
// Command, CPU-arbitration, memory and transform-unit signals of the block-transform scheduler.
// The checksum signal exists only when XFORM_SCHED_CHECKSUM_EN is defined.
interface xform_sched_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 19
);
  logic              start;
  logic [1:0]        op;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len;
  logic              cpu_mem_req;
  logic              cpu_stall;
  logic [ADDR_W-1:0] eng_mem_addr;
  logic              eng_mem_read;
  logic              eng_mem_write;
  logic [DATA_W-1:0] eng_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] xf_a;
  logic              encr_en;
  logic              decr_en;
  logic              fft_en;
  logic [DATA_W-1:0] xf_result;
  logic              busy;
  logic              done;
  logic              err;
`ifdef XFORM_SCHED_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  modport slave (
    input  start, op, base, len, cpu_mem_req, mem_rdata, xf_result,
    output cpu_stall, eng_mem_addr, eng_mem_read, eng_mem_write, eng_wdata, xf_a,
    output encr_en, decr_en, fft_en, busy, done, err
`ifdef XFORM_SCHED_CHECKSUM_EN
    , output checksum
`endif
  );

  modport master (
    output start, op, base, len, cpu_mem_req, mem_rdata, xf_result,
    input  cpu_stall, eng_mem_addr, eng_mem_read, eng_mem_write, eng_wdata, xf_a,
    input  encr_en, decr_en, fft_en, busy, done, err
`ifdef XFORM_SCHED_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/xform_sched.sv
// Block-transform scheduler: read/transform/write over a word range, sharing the memory port
// with the CPU. Optional running checksum of written words under XFORM_SCHED_CHECKSUM_EN.
module xform_sched #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DATA_W       = 19,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset,
  xform_sched_if.slave bus
);
  localparam int unsigned CntW    = ADDR_W + 1;
  localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] MaxLen = CntW'(2 ** ADDR_W);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                err_q, err_d;

  logic busy, grant, starve_hit, legal, accept, wr_grant;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    count_d  = count_q;
    data_d   = data_q;
    starve_d = starve_q;

    bus.eng_mem_addr  = '0;
    bus.eng_mem_read  = 1'b0;
    bus.eng_mem_write = 1'b0;
    bus.eng_wdata     = '0;
    bus.xf_a          = '0;
    bus.encr_en       = 1'b0;
    bus.decr_en       = 1'b0;
    bus.fft_en        = 1'b0;
    wr_grant          = 1'b0;

    busy       = (state_q == StRead) || (state_q == StWrite);
    starve_hit = (starve_q == StarveW'(STARVE_LIMIT));
    // CPU owns the port unless the engine has waited STARVE_LIMIT cycles in a row.
    grant         = busy && (!bus.cpu_mem_req || starve_hit);
    bus.cpu_stall = busy && bus.cpu_mem_req && starve_hit;

    legal  = (bus.op != 2'b11) && (bus.len != '0) && (bus.len <= MaxLen);
    accept = (state_q == StIdle) && bus.start && legal;
    err_d  = bus.start && !accept;

    if (busy) starve_d = grant ? '0 : starve_q + StarveW'(1);

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StRead;
          op_d     = bus.op;
          addr_d   = bus.base;
          count_d  = bus.len;
          starve_d = '0;
        end
      end
      StRead: begin
        if (grant) begin
          bus.eng_mem_read = 1'b1;
          bus.eng_mem_addr = addr_q;
          data_d           = bus.mem_rdata;
          state_d          = StWrite;
        end
      end
      StWrite: begin
        bus.xf_a = data_q;
        if (grant) begin
          wr_grant          = 1'b1;
          bus.eng_mem_write = 1'b1;
          bus.eng_mem_addr  = addr_q;
          bus.eng_wdata     = bus.xf_result;
          unique case (op_q)
            2'b00:   bus.encr_en = 1'b1;
            2'b01:   bus.decr_en = 1'b1;
            2'b10:   bus.fft_en  = 1'b1;
            default: ;
          endcase
          addr_d  = addr_q + ADDR_W'(1);
          count_d = count_q - CntW'(1);
          state_d = (count_q == CntW'(1)) ? StDone : StRead;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    bus.busy = busy;
    bus.done = (state_q == StDone);
    bus.err  = err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      data_q   <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

`ifdef XFORM_SCHED_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (accept) begin
      checksum_d = '0;
    end else if (wr_grant) begin
      checksum_d = checksum_q + bus.xf_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign bus.checksum = checksum_q;
`endif
endmodule

// File: tb/tb_xform_sched.sv
// Self-checking bench for xform_sched: transaction-queue reference model compared every cycle,
// directed scenarios pinned by literal expectations, then randomized traffic.
module tb_xform_sched;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 19;
  localparam int unsigned SL    = 4;
  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  xform_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  xform_sched #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [DW-1:0] mem  [Depth];
  logic [DW-1:0] mmem [Depth];

  // Stand-ins for the transform units.
  function automatic logic [DW-1:0] xf(input logic [1:0] op, input logic [DW-1:0] a);
    case (op)
      2'd0:    return a ^ 19'h2AAAA;
      2'd1:    return a - 19'h01234;
      2'd2:    return {a[15:0], a[18:16]};
      default: return '0;
    endcase
  endfunction

  assign bus.mem_rdata = mem[bus.eng_mem_addr];
  assign bus.xf_result = bus.encr_en ? xf(2'd0, bus.xf_a) :
                         bus.decr_en ? xf(2'd1, bus.xf_a) :
                         bus.fft_en  ? xf(2'd2, bus.xf_a) : '0;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
  } acc_t;

  acc_t          mq[$];
  int unsigned   m_starve;
  logic [1:0]    m_op;
  logic [DW-1:0] m_lat;
  logic [DW-1:0] m_sum;
  bit            m_in_done;
  bit            m_err;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit last_done;
  int n_busy, n_stall, n_err;
  logic [AW-1:0] wr_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: compare against the model mid-cycle, then advance model and memory.
  task automatic step();
    bit            busy_e, grant, rd_e, wr_e, stall_e, was_done;
    logic [AW-1:0] a_e;
    logic [DW-1:0] wd_e, xa_e;
    logic [2:0]    en_e;
    acc_t          f;
    @(negedge clk);
    busy_e = (mq.size() != 0);
    f = '0;
    if (busy_e) f = mq[0];
    grant   = busy_e && (!bus.cpu_mem_req || m_starve == SL);
    stall_e = busy_e && bus.cpu_mem_req && (m_starve == SL);
    rd_e    = grant && !f.wr;
    wr_e    = grant && f.wr;
    a_e     = grant ? f.addr : '0;
    wd_e    = wr_e ? xf(m_op, m_lat) : '0;
    xa_e    = (busy_e && f.wr) ? m_lat : '0;
    en_e    = wr_e ? (3'b001 << m_op) : 3'b000;

    chk("busy",      32'(bus.busy),          32'(busy_e));
    chk("done",      32'(bus.done),          32'(m_in_done));
    chk("err",       32'(bus.err),           32'(m_err));
    chk("cpu_stall", 32'(bus.cpu_stall),     32'(stall_e));
    chk("mem_read",  32'(bus.eng_mem_read),  32'(rd_e));
    chk("mem_write", 32'(bus.eng_mem_write), 32'(wr_e));
    chk("mem_addr",  32'(bus.eng_mem_addr),  32'(a_e));
    chk("wdata",     32'(bus.eng_wdata),     32'(wd_e));
    chk("xf_a",      32'(bus.xf_a),          32'(xa_e));
    chk("enables",   32'({bus.fft_en, bus.decr_en, bus.encr_en}), 32'(en_e));
`ifdef XFORM_SCHED_CHECKSUM_EN
    chk("checksum",  32'(bus.checksum),      32'(m_sum));
`endif

    last_done = bus.done;
    if (bus.busy) n_busy++;
    if (bus.cpu_stall) n_stall++;
    if (bus.err) n_err++;
    if (bus.eng_mem_write) begin
      wr_log.push_back(bus.eng_mem_addr);
      mem[bus.eng_mem_addr] = bus.eng_wdata;
    end

    if (grant) begin
      void'(mq.pop_front());
      if (f.wr) begin
        mmem[f.addr] = wd_e;
        m_sum = m_sum + wd_e;
      end else begin
        m_lat = mmem[f.addr];
      end
    end
    was_done = m_in_done;
    if (reset) begin
      mq.delete();
      m_starve  = 0;
      m_in_done = 0;
      m_err     = 0;
      m_sum     = '0;
    end else begin
      m_err     = 0;
      m_in_done = grant && f.wr && (mq.size() == 0);
      if (busy_e) m_starve = grant ? 0 : m_starve + 1;
      if (bus.start) begin
        if (!busy_e && !was_done && bus.op != 2'b11 && bus.len >= 1 && bus.len <= Depth) begin
          m_op     = bus.op;
          m_starve = 0;
          m_sum    = '0;
          for (int i = 0; i < int'(bus.len); i++) begin
            mq.push_back({1'b0, AW'(int'(bus.base) + i)});
            mq.push_back({1'b1, AW'(int'(bus.base) + i)});
          end
        end else begin
          m_err = 1;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int a, input logic [DW-1:0] v);
    mem[a]  = v;
    mmem[a] = v;
  endtask

  // Issue one command at cycle 0; optional extra start (base 9) and reset at given cycles.
  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] b, input logic [AW:0] l,
                         input bit req, input int inj, input int rst_at, output int done_at);
    done_at = -1;
    n_busy  = 0;
    n_stall = 0;
    n_err   = 0;
    wr_log.delete();
    bus.start = 1'b1;
    bus.op    = op;
    bus.base  = b;
    bus.len   = l;
    bus.cpu_mem_req = req;
    reset = 1'b0;
    step();
    for (int k = 1; k <= 60; k++) begin
      bus.start = (k == inj);
      if (k == inj) bus.base = 4'd9;
      reset = (k == rst_at);
      step();
      if (reset) begin
        reset = 1'b0;
        break;
      end
      if (last_done) begin
        done_at = k;
        break;
      end
    end
    bus.start = 1'b0;
    bus.cpu_mem_req = 1'b0;
  endtask

  task automatic illegal(input logic [1:0] op, input logic [AW:0] l, input string name);
    wr_log.delete();
    bus.start = 1'b1;
    bus.op    = op;
    bus.len   = l;
    bus.base  = 4'd0;
    step();
    bus.start = 1'b0;
    chk({name, "_err"}, 32'(bus.err), 32'd1);
    step();
    chk({name, "_err_once"}, 32'(bus.err), 32'd0);
    chk({name, "_idle"}, 32'(bus.busy), 32'd0);
    chk({name, "_no_access"}, 32'(wr_log.size()), 32'd0);
  endtask

  initial begin
    int d;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.base = '0;
    bus.len = '0;
    bus.cpu_mem_req = 1'b0;
    m_starve = 0; m_op = '0; m_lat = '0; m_sum = '0; m_in_done = 0; m_err = 0;
    n_busy = 0; n_stall = 0; n_err = 0; last_done = 0;
    for (int i = 0; i < int'(Depth); i++) preload(i, DW'($urandom));
    step();
    step();
    reset = 1'b0;
    chk("rst_busy",  32'(bus.busy),          32'd0);
    chk("rst_done",  32'(bus.done),          32'd0);
    chk("rst_err",   32'(bus.err),           32'd0);
    chk("rst_write", 32'(bus.eng_mem_write), 32'd0);

    // Basic encrypt.
    preload(2, 19'd5); preload(3, 19'd6); preload(4, 19'd7);
    run_cmd(2'd0, 4'd2, 5'd3, 1'b0, -1, -1, d);
    chk("enc_done_cycle", 32'(d), 32'd7);
    chk("enc_busy_cycles", 32'(n_busy), 32'd6);
    chk("enc_no_stall", 32'(n_stall), 32'd0);
    chk("enc_mem2", 32'(mem[2]), 32'h2AAAF);
    chk("enc_mem3", 32'(mem[3]), 32'h2AAAC);
    chk("enc_mem4", 32'(mem[4]), 32'h2AAAD);

    // Wrap-around FFT.
    preload(14, 19'd1); preload(15, 19'd2); preload(0, 19'd3); preload(1, 19'h40000);
    preload(2, 19'h12345);
    run_cmd(2'd2, 4'd14, 5'd4, 1'b0, -1, -1, d);
    chk("wrap_done_cycle", 32'(d), 32'd9);
    chk("wrap_nwrites", 32'(wr_log.size()), 32'd4);
    if (wr_log.size() == 4) begin
      chk("wrap_order0", 32'(wr_log[0]), 32'd14);
      chk("wrap_order1", 32'(wr_log[1]), 32'd15);
      chk("wrap_order2", 32'(wr_log[2]), 32'd0);
      chk("wrap_order3", 32'(wr_log[3]), 32'd1);
    end
    chk("wrap_mem14", 32'(mem[14]), 32'd8);
    chk("wrap_mem15", 32'(mem[15]), 32'd16);
    chk("wrap_mem0",  32'(mem[0]),  32'd24);
    chk("wrap_mem1",  32'(mem[1]),  32'd4);
    chk("wrap_mem2",  32'(mem[2]),  32'h12345);

    // Contention with continuous CPU requests.
    preload(7, 19'h01300);
    run_cmd(2'd1, 4'd7, 5'd1, 1'b1, -1, -1, d);
    chk("starve_done_cycle", 32'(d), 32'd11);
    chk("starve_stalls", 32'(n_stall), 32'd2);
    chk("starve_mem7", 32'(mem[7]), 32'hCC);
    run_cmd(2'd0, 4'd10, 5'd3, 1'b1, -1, -1, d);
    chk("starve3_done_cycle", 32'(d), 32'd31);
    chk("starve3_stalls", 32'(n_stall), 32'd6);

    // Illegal commands.
    illegal(2'd0, 5'd0,  "len0");
    illegal(2'd3, 5'd2,  "op3");
    illegal(2'd1, 5'd17, "len17");

    // Start while busy.
    preload(9, 19'h11111);
    run_cmd(2'd0, 4'd5, 5'd3, 1'b0, 2, -1, d);
    chk("busyrej_done_cycle", 32'(d), 32'd7);
    chk("busyrej_err_count", 32'(n_err), 32'd1);
    chk("busyrej_nwrites", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) chk("busyrej_last_addr", 32'(wr_log[2]), 32'd7);
    chk("busyrej_mem9", 32'(mem[9]), 32'h11111);

    // Reset mid-operation.
    preload(3, 19'h00100); preload(4, 19'h00101); preload(5, 19'h00102); preload(6, 19'h00103);
    run_cmd(2'd0, 4'd3, 5'd4, 1'b0, -1, 3, d);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_done", 32'(bus.done), 32'd0);
    chk("rstmid_en", 32'({bus.eng_mem_read, bus.eng_mem_write, bus.encr_en}), 32'd0);
    chk("rstmid_nwrites", 32'(wr_log.size()), 32'd1);
    chk("rstmid_mem3", 32'(mem[3]), 32'h2ABAA);
    chk("rstmid_mem4", 32'(mem[4]), 32'h00101);
    run_cmd(2'd0, 4'd8, 5'd1, 1'b0, -1, -1, d);
    chk("rstmid_restart_done", 32'(d), 32'd3);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.start = ($urandom_range(0, 5) == 0);
      bus.op    = 2'($urandom_range(0, 3));
      bus.base  = AW'($urandom);
      bus.len   = 5'($urandom_range(0, 17));
      bus.cpu_mem_req = ($urandom_range(0, 99) < 45);
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    bus.start = 1'b0;
    bus.cpu_mem_req = 1'b0;
    repeat (80) step();
    for (int i = 0; i < int'(Depth); i++) chk("final_mem", 32'(mem[i]), 32'(mmem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/xform_sched.md
Name: xform_sched

Overview:
- Block-transform scheduler for the CPU's 16-entry × 19-bit data memory.
- On a start command it walks a range of memory words. For each word it reads the word, routes it through the existing encrypt/decrypt/FFT combinational units, and writes the result back to the same address.
- It shares the single data-memory port with the CPU pipeline through a priority arbiter with a starvation guard.
- It sits between the CPU memory-request signals and the data memory.

Parameters:
- ADDR_W, 4, data memory address width (depth = 2**ADDR_W).
- DATA_W, 19, word width.
- STARVE_LIMIT, 4, number of consecutive stalled engine cycles after which the engine is granted one cycle over the CPU.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  command strobe, sampled every cycle
- op  in  2  00 encrypt, 01 decrypt, 10 fft, 11 illegal
- base  in  ADDR_W  first word address
- len  in  ADDR_W+1  word count, legal range 1..16
- cpu_mem_req  in  1  CPU wants the memory port this cycle (mem_read or mem_write)
- cpu_stall  out  1  CPU request denied this cycle; pipeline must hold
- eng_mem_addr  out  ADDR_W  engine address to the memory mux
- eng_mem_read  out  1  engine read this cycle
- eng_mem_write  out  1  engine write this cycle
- eng_wdata  out  DATA_W  engine write data (= xf_result)
- mem_rdata  in  DATA_W  combinational memory read data
- xf_a  out  DATA_W  operand to the transform units
- encr_en, decr_en, fft_en  out  1 each  transform select, one-hot, high only in WRITE
- xf_result  in  DATA_W  selected transform result
- busy  out  1  engine active
- done  out  1  one-cycle pulse at completion
- err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- On reset:
  - state=IDLE.
  - All outputs 0.
  - addr/count/data/starve registers cleared.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - start with legal op and 1≤len≤16 latches op, base and len, then goes to READ next cycle.
  - start with op=11, len=0 or len>16 pulses err the next cycle and stays IDLE.
- READ, when granted:
  - eng_mem_read=1, eng_mem_addr=cur_addr.
  - mem_rdata is latched into data_reg.
  - Next state is WRITE.
- WRITE, when granted:
  - xf_a=data_reg, the op enable is high, eng_mem_write=1, eng_wdata=xf_result, eng_mem_addr=cur_addr.
  - Then cur_addr increments modulo 2**ADDR_W (wraps 15→0) and the remaining count decrements.
  - Next state is READ, or DONE if the remaining count is 0.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 in READ and WRITE only.
- Uncontested latency: start accepted at cycle 0; READ at cycle 1; done asserted at cycle 2·len+1.
- Arbitration applies in READ and WRITE only:
  - CPU wins by default. If cpu_mem_req=1, the engine is not granted: eng_mem_read, eng_mem_write and enables are 0, state holds, and starve_cnt increments.
  - When starve_cnt==STARVE_LIMIT and cpu_mem_req=1, the engine is granted and cpu_stall=1 for that cycle only; starve_cnt then clears.
  - Any granted engine cycle clears starve_cnt.
  - cpu_stall is 0 in every other case, including whenever the engine is not busy.
- eng_mem_read and eng_mem_write are never both 1. The engine never drives the port in IDLE or DONE.
- start while busy or in DONE is ignored, err pulses, and the current operation is unaffected.
- Reset mid-operation aborts immediately. The last granted write stays in memory; no done pulse.
- Simultaneous start and reset: reset wins.

Optional Feature:
- Macro: XFORM_SCHED_CHECKSUM_EN.
- When defined:
  - Adds output checksum (DATA_W).
  - checksum clears on command acceptance.
  - On each granted WRITE it adds eng_wdata modulo 2**DATA_W.
  - The value is held stable from DONE until the next acceptance; reset clears it to 0.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Test Plan:
- Basic encrypt:
  - Stimulus: mem[2..4]={5,6,7}, start op=00 base=2 len=3, cpu_mem_req=0. The model returns xf_result=a^19'h2AAAA.
  - Required: mem[2..4]=a^19'h2AAAA, done at cycle 7, busy high cycles 1–6, cpu_stall never 1.
- Wrap-around: start op=10 base=14 len=4 → writes addresses 14,15,0,1 in order; mem[2] untouched; done at cycle 9.
- Contention and starvation, STARVE_LIMIT=4:
  - Stimulus: hold cpu_mem_req=1 continuously after acceptance.
  - Required: the engine stalls 4 cycles, then is granted with cpu_stall=1 for one cycle. The pattern repeats; a len=1 operation completes with done at cycle 11.
- Illegal commands: len=0, then op=11, then len=17 → each gives a single-cycle err; state stays IDLE; no memory access.
- Busy rejection: start during an operation with base=9 → err pulses; the original operation completes with its original addresses; mem[9] unchanged.
- Reset mid-op: assert reset in the 3rd cycle of a len=4 operation → the next cycle shows busy=0, done=0 and all enables 0. Only mem[base] is written. A new start is accepted normally afterwards.
